// File: rtl/cv_frame_scheduler.sv
// cv_frame_scheduler: synchronises SPI CV frames into i_Clock, shadows them and commits on the sample strobe
//
// Ports:
//   i_Clock, i_Reset          system clock, synchronous active-high reset
//   i_Frame_Done              asynchronous frame-valid level from the SPI receiver
//   i_Data0..i_Data4          CV words, stable while i_Frame_Done is high
//   i_Sample_Strobe           one-cycle pulse at the audio sample rate
//   o_CV0..o_CV4              committed CV values
//   o_Update                  one-cycle pulse when o_CVx were written
//   o_Link_OK                 frames arriving within TIMEOUT_CYCLES
//   o_Overrun                 sticky: a captured frame was replaced before it was committed
//   o_Frame_Count             captured-frame counter, wraps 255->0
//
// Optional feature macro: CV_TIMEOUT_DEFAULT_EN (load DEFAULT_CV on the first strobe after a link timeout)
module cv_frame_scheduler #(
    parameter int CHANNELS = 5,
    parameter int WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter logic [WIDTH-1:0] DEFAULT_CV = '0
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Frame_Done,
    input  logic [WIDTH-1:0] i_Data0,
    input  logic [WIDTH-1:0] i_Data1,
    input  logic [WIDTH-1:0] i_Data2,
    input  logic [WIDTH-1:0] i_Data3,
    input  logic [WIDTH-1:0] i_Data4,
    input  logic             i_Sample_Strobe,
    output logic [WIDTH-1:0] o_CV0,
    output logic [WIDTH-1:0] o_CV1,
    output logic [WIDTH-1:0] o_CV2,
    output logic [WIDTH-1:0] o_CV3,
    output logic [WIDTH-1:0] o_CV4,
    output logic             o_Update,
    output logic             o_Link_OK,
    output logic             o_Overrun,
    output logic [7:0]       o_Frame_Count
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

`ifdef CV_TIMEOUT_DEFAULT_EN
    typedef enum logic [1:0] {IDLE, PENDING, TOUT} state_t;
    localparam state_t TIMEOUT_STATE = TOUT;
`else
    typedef enum logic [1:0] {IDLE, PENDING} state_t;
    localparam state_t TIMEOUT_STATE = IDLE;
    logic unused_default;
    assign unused_default = ^DEFAULT_CV;
`endif

    state_t state;
    logic sync_meta, sync_q, sync_prev;
    logic [WD_W-1:0] watchdog;
    logic [WIDTH-1:0] din [CHANNELS];
    logic [WIDTH-1:0] shadow [CHANNELS];
    logic [WIDTH-1:0] cv [CHANNELS];
    logic capture, timeout;

    assign din[0] = i_Data0;
    assign din[1] = i_Data1;
    assign din[2] = i_Data2;
    assign din[3] = i_Data3;
    assign din[4] = i_Data4;
    assign o_CV0 = cv[0];
    assign o_CV1 = cv[1];
    assign o_CV2 = cv[2];
    assign o_CV3 = cv[3];
    assign o_CV4 = cv[4];

    // Capture lands on the third edge after the flag rises: meta, sync, then the prev flop closes the edge.
    assign capture = sync_q & ~sync_prev;
    // Fires once, on the edge where the watchdog reaches its saturation value.
    assign timeout = ~capture & (watchdog == WD_LAST);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sync_meta <= 1'b0;
            sync_q <= 1'b0;
            sync_prev <= 1'b0;
            watchdog <= '0;
            shadow <= '{default: '0};
            cv <= '{default: '0};
            state <= IDLE;
            o_Update <= 1'b0;
            o_Link_OK <= 1'b0;
            o_Overrun <= 1'b0;
            o_Frame_Count <= 8'd0;
        end else begin
            sync_meta <= i_Frame_Done;
            sync_q <= sync_meta;
            sync_prev <= sync_q;
            o_Update <= 1'b0;
            watchdog <= capture ? '0 : (watchdog == WD_MAX ? watchdog : watchdog + WD_W'(1));
            if (capture) begin
                shadow <= din;
                o_Frame_Count <= o_Frame_Count + 8'd1;
                o_Link_OK <= 1'b1;
                state <= PENDING;
                // A strobe coinciding with a new capture still commits the frame it replaces.
                if (state == PENDING) begin
                    if (i_Sample_Strobe) begin
                        cv <= shadow;
                        o_Update <= 1'b1;
                    end else begin
                        o_Overrun <= 1'b1;
                    end
                end
            end else if (timeout) begin
                o_Link_OK <= 1'b0;
                state <= TIMEOUT_STATE;
            end else if (i_Sample_Strobe && state == PENDING) begin
                cv <= shadow;
                o_Update <= 1'b1;
                state <= IDLE;
            end
`ifdef CV_TIMEOUT_DEFAULT_EN
            else if (i_Sample_Strobe && state == TOUT) begin
                cv <= '{default: DEFAULT_CV};
                o_Update <= 1'b1;
                state <= IDLE;
            end
`endif
        end
    end
endmodule
